// File: rtl/gps_pkg.sv
// Shared definitions for the GPS prompt accumulate-and-dump stage:
// FSM encoding, default widths and the 1-bit prompt encoding.
package gps_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        ACCUM = 2'd2
    } gps_state_e;

    localparam int ACC_WIDTH_DEF       = 16;
    localparam int EPOCH_CNT_WIDTH_DEF = 8;

    // A prompt bit of 1 means +1, 0 means -1.
    localparam logic PROMPT_PLUS_ONE = 1'b1;

endpackage

// File: rtl/gps_sat_accum.sv
// One arm (I or Q) of the prompt integrator: symmetric saturating +/-1 counter.
// sum_o is the sum including the current cycle's sample, so a dump can capture it.
module gps_sat_accum
    import gps_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clr,
    input  logic                        inc_valid,
    input  logic                        sample_bit,
    output logic signed [ACC_WIDTH-1:0] sum_o
);

    // Symmetric limits: the most negative code is never produced.
    localparam logic signed [ACC_WIDTH-1:0] SUM_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SUM_MIN  = {1'b1, {(ACC_WIDTH-2){1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH-1:0] SUM_ONE  = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH-1:0] SUM_ZERO = {ACC_WIDTH{1'b0}};

    logic signed [ACC_WIDTH-1:0] sum_q;
    logic signed [ACC_WIDTH-1:0] sum_nxt_s;
    logic signed [ACC_WIDTH-1:0] sum_d;

    always_comb begin
        sum_nxt_s = sum_q;
        if (inc_valid) begin
            if (sample_bit == PROMPT_PLUS_ONE) begin
                if (sum_q != SUM_MAX) begin
                    sum_nxt_s = sum_q + SUM_ONE;
                end else begin
                    sum_nxt_s = sum_q;
                end
            end else begin
                if (sum_q != SUM_MIN) begin
                    sum_nxt_s = sum_q - SUM_ONE;
                end else begin
                    sum_nxt_s = sum_q;
                end
            end
        end else begin
            sum_nxt_s = sum_q;
        end

        if (clr) begin
            sum_d = SUM_ZERO;
        end else begin
            sum_d = sum_nxt_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= SUM_ZERO;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_nxt_s;

endmodule

// File: rtl/gps_accumulator.sv
// Accumulate-and-dump correlator stage: integrates prompt I/Q over one C/A epoch
// and hands the signed sums to a reader via valid/ready, flagging lost dumps.
module gps_accumulator
    import gps_pkg::*;
#(
    parameter int ACC_WIDTH       = ACC_WIDTH_DEF,
    parameter int EPOCH_CNT_WIDTH = EPOCH_CNT_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        sample_valid,
    input  logic                        prompt_i,
    input  logic                        prompt_q,
    input  logic                        epoch,
    input  logic                        dump_ready,
    input  logic                        clear_overrun,
    output logic                        dump_valid,
    output logic signed [ACC_WIDTH-1:0] dump_i,
    output logic signed [ACC_WIDTH-1:0] dump_q,
    output logic [EPOCH_CNT_WIDTH-1:0]  epoch_count,
    output logic                        overrun,
    output logic [1:0]                  state
);

    localparam logic [EPOCH_CNT_WIDTH-1:0] CNT_ONE = {{(EPOCH_CNT_WIDTH-1){1'b0}}, 1'b1};

    gps_state_e state_q, state_d;

    logic                        accum_active_s;
    logic                        dump_now_s;
    logic                        inc_s;
    logic                        clr_s;
    logic                        xfer_s;
    logic signed [ACC_WIDTH-1:0] run_i_s;
    logic signed [ACC_WIDTH-1:0] run_q_s;

    logic                        dump_valid_q, dump_valid_d;
    logic signed [ACC_WIDTH-1:0] dump_i_q, dump_i_d;
    logic signed [ACC_WIDTH-1:0] dump_q_q, dump_q_d;
    logic [EPOCH_CNT_WIDTH-1:0]  epoch_count_q, epoch_count_d;
    logic                        overrun_q, overrun_d;

    assign accum_active_s = enable && (state_q == ACCUM);
    assign dump_now_s     = accum_active_s && epoch;
    assign inc_s          = accum_active_s && sample_valid;
    // Sums are held at zero outside ACCUM and restart after every dump.
    assign clr_s          = !accum_active_s || epoch;
    assign xfer_s         = dump_valid_q && dump_ready;

    gps_sat_accum #(.ACC_WIDTH(ACC_WIDTH)) u_arm_i (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr_s),
        .inc_valid  (inc_s),
        .sample_bit (prompt_i),
        .sum_o      (run_i_s)
    );

    gps_sat_accum #(.ACC_WIDTH(ACC_WIDTH)) u_arm_q (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr_s),
        .inc_valid  (inc_s),
        .sample_bit (prompt_q),
        .sum_o      (run_q_s)
    );

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ALIGN;
                ALIGN: begin
                    if (epoch) begin
                        state_d = ACCUM;
                    end else begin
                        state_d = ALIGN;
                    end
                end
                ACCUM:   state_d = ACCUM;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A dump coinciding with a transfer replaces the taken result without loss.
    always_comb begin
        dump_valid_d  = dump_valid_q;
        dump_i_d      = dump_i_q;
        dump_q_d      = dump_q_q;
        epoch_count_d = epoch_count_q;
        overrun_d     = overrun_q;

        if (dump_now_s) begin
            dump_valid_d  = 1'b1;
            dump_i_d      = run_i_s;
            dump_q_d      = run_q_s;
            epoch_count_d = epoch_count_q + CNT_ONE;
        end else if (xfer_s) begin
            dump_valid_d  = 1'b0;
        end else begin
            dump_valid_d  = dump_valid_q;
        end

        if (dump_now_s && dump_valid_q && !dump_ready) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dump_valid_q  <= 1'b0;
            dump_i_q      <= {ACC_WIDTH{1'b0}};
            dump_q_q      <= {ACC_WIDTH{1'b0}};
            epoch_count_q <= {EPOCH_CNT_WIDTH{1'b0}};
            overrun_q     <= 1'b0;
        end else begin
            dump_valid_q  <= dump_valid_d;
            dump_i_q      <= dump_i_d;
            dump_q_q      <= dump_q_d;
            epoch_count_q <= epoch_count_d;
            overrun_q     <= overrun_d;
        end
    end

    assign dump_valid  = dump_valid_q;
    assign dump_i      = dump_i_q;
    assign dump_q      = dump_q_q;
    assign epoch_count = epoch_count_q;
    assign overrun     = overrun_q;
    assign state       = state_q;

endmodule

// File: tb/tb_gps_accumulator.sv
// Self-checking bench: two instances (16-bit and 4-bit sums) share stimulus and
// are compared every cycle against an epoch-level behavioural model.
module tb_gps_accumulator;

    logic clk = 1'b0;
    logic reset_n, enable, sample_valid, prompt_i, prompt_q, epoch, dump_ready, clear_overrun;

    logic               a_valid, b_valid, a_ovr, b_ovr;
    logic signed [15:0] a_di, a_dq;
    logic signed [3:0]  b_di, b_dq;
    logic [7:0]         a_cnt, b_cnt;
    logic [1:0]         a_state, b_state;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: phase 0 idle, 1 waiting for alignment epoch, 2 integrating.
    int phase;
    int lim   [2] = '{32767, 7};
    int m_ri  [2];
    int m_rq  [2];
    int m_di  [2];
    int m_dq  [2];
    int m_valid, m_cnt, m_ovr;

    always #5 clk = ~clk;

    gps_accumulator u_dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
        .prompt_i(prompt_i), .prompt_q(prompt_q), .epoch(epoch), .dump_ready(dump_ready),
        .clear_overrun(clear_overrun), .dump_valid(a_valid), .dump_i(a_di), .dump_q(a_dq),
        .epoch_count(a_cnt), .overrun(a_ovr), .state(a_state)
    );

    gps_accumulator #(.ACC_WIDTH(4), .EPOCH_CNT_WIDTH(8)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
        .prompt_i(prompt_i), .prompt_q(prompt_q), .epoch(epoch), .dump_ready(dump_ready),
        .clear_overrun(clear_overrun), .dump_valid(b_valid), .dump_i(b_di), .dump_q(b_dq),
        .epoch_count(b_cnt), .overrun(b_ovr), .state(b_state)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int l);
        if (v > l) return l;
        if (v < -l) return -l;
        return v;
    endfunction

    task automatic model_reset();
        phase = 0; m_valid = 0; m_cnt = 0; m_ovr = 0;
        for (int k = 0; k < 2; k++) begin
            m_ri[k] = 0; m_rq[k] = 0; m_di[k] = 0; m_dq[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit dump;
        bit xfer;
        bit ovr_set;
        dump    = 1'b0;
        xfer    = (m_valid != 0) && dump_ready;
        ovr_set = 1'b0;
        if (!enable) begin
            phase = 0;
            for (int k = 0; k < 2; k++) begin m_ri[k] = 0; m_rq[k] = 0; end
        end else if (phase == 0) begin
            phase = 1;
        end else if (phase == 1) begin
            if (epoch) phase = 2;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sample_valid) begin
                    m_ri[k] = clamp(m_ri[k] + (prompt_i ? 1 : -1), lim[k]);
                    m_rq[k] = clamp(m_rq[k] + (prompt_q ? 1 : -1), lim[k]);
                end
                if (epoch) begin
                    m_di[k] = m_ri[k]; m_dq[k] = m_rq[k];
                    m_ri[k] = 0;       m_rq[k] = 0;
                end
            end
            dump = epoch;
        end
        if (dump) begin
            if (m_valid != 0 && !xfer) ovr_set = 1'b1;
            m_valid = 1;
            m_cnt   = (m_cnt + 1) % 256;
        end else if (xfer) begin
            m_valid = 0;
        end
        if (ovr_set) m_ovr = 1;
        else if (clear_overrun) m_ovr = 0;
    endtask

    task automatic compare_all();
        check("state_a", int'(a_state), phase);
        check("state_b", int'(b_state), phase);
        check("valid_a", int'(a_valid), m_valid);
        check("valid_b", int'(b_valid), m_valid);
        check("count",   int'(a_cnt), m_cnt);
        check("overrun", int'(a_ovr), m_ovr);
        check("dump_i_a", int'(a_di), m_di[0]);
        check("dump_q_a", int'(a_dq), m_dq[0]);
        check("dump_i_b", int'(b_di), m_di[1]);
        check("dump_q_b", int'(b_dq), m_dq[1]);
    endtask

    task automatic step(input logic en, input logic sv, input logic pi, input logic pq,
                        input logic ep, input logic rdy, input logic clr);
        enable = en; sample_valid = sv; prompt_i = pi; prompt_q = pq;
        epoch = ep; dump_ready = rdy; clear_overrun = clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic sample(input logic pi, input logic pq, input logic ep);
        step(1'b1, 1'b1, pi, pq, ep, 1'b0, 1'b0);
    endtask

    task automatic read_dump();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; prompt_i = 1'b0; prompt_q = 1'b0;
        epoch = 1'b0; dump_ready = 1'b0; clear_overrun = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("rst_valid", int'(a_valid), 0);
        check("rst_state", int'(a_state), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic dump
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tp1_align", int'(a_state), 1);
        sample(1'b1, 1'b1, 1'b1);
        check("tp1_accum", int'(a_state), 2);
        for (int j = 0; j < 10; j++) begin
            sample((j < 7) ? 1'b1 : 1'b0, 1'b0, (j == 9) ? 1'b1 : 1'b0);
            if (j == 8) check("tp1_novalid", int'(a_valid), 0);
        end
        check("tp1_i", int'(a_di), 4);
        check("tp1_q", int'(a_dq), -10);
        check("tp1_valid", int'(a_valid), 1);
        check("tp1_cnt", int'(a_cnt), 1);
        read_dump();
        check("tp1_read", int'(a_valid), 0);

        // Alignment discards pre-epoch samples
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) sample(1'b1, 1'b1, (j == 4) ? 1'b1 : 1'b0);
        check("tp2_nodump", int'(a_valid), 0);
        sample(1'b1, 1'b0, 1'b0);
        sample(1'b1, 1'b0, 1'b1);
        check("tp2_i", int'(a_di), 2);
        check("tp2_q", int'(a_dq), -2);
        check("tp2_cnt", int'(a_cnt), 2);
        read_dump();

        // Overrun and dump coincident with transfer
        for (int r = 0; r < 2; r++) begin
            sample(1'b1, 1'b1, 1'b0); sample(1'b1, 1'b1, 1'b0); sample(1'b1, 1'b1, 1'b1);
            check("tp3_first", int'(a_di), 3);
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, (r == 1) ? 1'b1 : 1'b0, 1'b0);
            check("tp3_i", int'(a_di), -1);
            check("tp3_valid", int'(a_valid), 1);
            check("tp3_ovr", int'(a_ovr), (r == 0) ? 1 : 0);
            if (r == 0) begin
                step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                check("tp3_clr", int'(a_ovr), 0);
            end
            read_dump();
        end
        check("tp3_cnt", int'(a_cnt), 6);

        // Saturation on the 4-bit instance
        for (int j = 0; j < 9; j++) sample(1'b1, 1'b1, (j == 8) ? 1'b1 : 1'b0);
        check("tp4_pos_b", int'(b_di), 7);
        check("tp4_pos_a", int'(a_di), 9);
        read_dump();
        for (int j = 0; j < 9; j++) sample(1'b0, 1'b0, (j == 8) ? 1'b1 : 1'b0);
        check("tp4_neg_b", int'(b_di), -7);
        check("tp4_neg_a", int'(a_di), -9);
        read_dump();

        // Enable drop with a dump pending
        sample(1'b1, 1'b1, 1'b1);
        sample(1'b1, 1'b1, 1'b0); sample(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("tp5_idle", int'(a_state), 0);
        check("tp5_pend", int'(a_valid), 1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("tp5_hold", int'(a_valid), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("tp5_readidle", int'(a_valid), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tp5_align", int'(a_state), 1);
        sample(1'b1, 1'b1, 1'b1);
        check("tp5_nodump", int'(a_valid), 0);
        check("tp5_cnt", int'(a_cnt), 9);
        sample(1'b1, 1'b0, 1'b1);
        check("tp5_dump", int'(a_di), 1);
        check("tp5_cnt2", int'(a_cnt), 10);

        // Asynchronous reset between edges while a dump is pending
        check("tp6_pre", int'(a_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("tp6_valid", int'(a_valid), 0);
        check("tp6_cnt", int'(a_cnt), 0);
        check("tp6_state", int'(a_state), 0);
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 32) != 0, $urandom % 2, $urandom % 2, $urandom % 2,
                 ($urandom % 12) == 0, ($urandom % 4) == 0, ($urandom % 16) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
